// File: rtl/alu_sequencer.sv
// Command sequencer for an external ALU: accepts one command at a time, drives
// the ALU input/output selects for one cycle, then captures and reports the result.
module alu_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_src,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [2:0]        alu_in_sel,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [6:0]        alu_out_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              err_ack,
  output logic [2:0]        state,
  output logic [7:0]        op_count
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_READY   = 3'd1,
    S_ISSUE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam logic [2:0] IN_RESET   = 3'b001;
  localparam logic [2:0] IN_LOAD    = 3'b010;
  localparam logic [2:0] IN_PERSIST = 3'b100;
  localparam logic [2:0] OP_MULT    = 3'd6;
  localparam logic [2:0] OP_CLR     = 3'd7;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [2:0]        in_sel_q, in_sel_d;
  logic [6:0]        out_sel_q, out_sel_d;
  logic [DATA_W-1:0] num1_q, num1_d;
  logic [DATA_W-1:0] num2_q, num2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [7:0]        count_q, count_d;
  logic              mult_err;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    in_sel_d    = IN_PERSIST;
    out_sel_d   = out_sel_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    count_d     = count_q;
    mult_err    = alu_ovf && (op_q == OP_MULT);

    case (state_q)
      S_OFF: begin
        if (en) state_d = S_READY;
      end
      S_READY: begin
        // A valid command wins over a simultaneous power-down request.
        if (cmd_valid) begin
          state_d   = S_ISSUE;
          op_d      = cmd_op;
          count_d   = count_q + 8'd1;
          num1_d    = cmd_a;
          num2_d    = cmd_b;
          in_sel_d  = (cmd_op == OP_CLR) ? IN_RESET : (cmd_src ? IN_PERSIST : IN_LOAD);
          out_sel_d = (cmd_op == OP_CLR) ? 7'b0 : (7'b1 << cmd_op);
        end else if (!en) begin
          state_d = S_OFF;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = (op_q == OP_CLR) ? '0 : alu_result;
        rsp_err_d   = mult_err;
        state_d     = mult_err ? S_ERROR : S_READY;
      end
      S_ERROR: begin
        if (err_ack) state_d = S_READY;
      end
      default: state_d = S_OFF;
    endcase

    cmd_ready_d = (state_d == S_READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_OFF;
      op_q        <= 3'd0;
      cmd_ready_q <= 1'b0;
      in_sel_q    <= IN_RESET;
      out_sel_q   <= 7'b0;
      num1_q      <= '0;
      num2_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cmd_ready_q <= cmd_ready_d;
      in_sel_q    <= in_sel_d;
      out_sel_q   <= out_sel_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      count_q     <= count_d;
    end
  end

  assign state       = state_q;
  assign cmd_ready   = cmd_ready_q;
  assign alu_in_sel  = in_sel_q;
  assign alu_out_sel = out_sel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign op_count    = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and a response scoreboard.
`timescale 1ns/1ps
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst, en, cmd_valid, cmd_ready, cmd_src, alu_ovf, err_ack;
  logic [2:0] cmd_op, alu_in_sel, state;
  logic [7:0] cmd_a, cmd_b, alu_num1, alu_num2, alu_result, rsp_data, op_count;
  logic [6:0] alu_out_sel;
  logic       rsp_valid, rsp_err;

  alu_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .err_ack(err_ack), .state(state), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  rsp_t       exp_q[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  logic [7:0] exp_acc = 8'h00;

  // Behavioural ALU: operand A latched at the end of ISSUE, accumulator updated in CAPTURE.
  logic [7:0] alu_opa = 8'h00;
  logic [7:0] alu_acc = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (state == 3'd2)
      alu_opa <= (alu_in_sel == 3'b010) ? alu_num1 : ((alu_in_sel == 3'b001) ? 8'h00 : alu_acc);
    if (state == 3'd3) alu_acc <= alu_result;
    else if (alu_in_sel == 3'b001) alu_acc <= 8'h00;
  end

  always_comb begin
    alu_result = 8'h00;
    case (alu_out_sel)
      7'b0000001: alu_result = alu_opa & alu_num2;
      7'b0000010: alu_result = alu_opa | alu_num2;
      7'b0000100: alu_result = alu_opa ^ alu_num2;
      7'b0001000: alu_result = ~alu_opa;
      7'b0010000: alu_result = alu_opa + alu_num2;
      7'b0100000: alu_result = alu_opa - alu_num2;
      7'b1000000: alu_result = 8'(alu_opa * alu_num2);
      default:    alu_result = 8'h00;
    endcase
  end

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~a;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return p[7:0];
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected got data=%h err=%b required no response", rsp_data, rsp_err);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_err !== e.err)
          $display("FAIL rsp_data got data=%h err=%b required data=%h err=%b", rsp_data, rsp_err, e.data, e.err);
        else passes++;
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_src = 1'b0;
    cmd_a = 8'h00; cmd_b = 8'h00; alu_ovf = 1'b0; err_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_acc = 8'h00;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic src, input logic [7:0] a, input logic [7:0] b,
                          input logic ovf, output logic [2:0] in_seen, output logic [6:0] out_seen,
                          output int acc_cyc);
    int n;
    logic [7:0] r;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_timeout got cmd_ready=%b required 1", cmd_ready);
    else passes++;
    r = model(op, src ? exp_acc : a, b);
    exp_acc = r;
    exp_q.push_back({r, ovf && (op == 3'd6)});
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_a = a; cmd_b = b; alu_ovf = ovf;
    @(negedge clk);
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    in_seen = alu_in_sel;
    out_seen = alu_out_sel;
    checks++;
    if (state !== 3'd2 || alu_num1 !== a || alu_num2 !== b || cmd_ready !== 1'b0)
      $display("FAIL issue_outputs got state=%0d num1=%h num2=%h ready=%b required 2 %h %h 0",
               state, alu_num1, alu_num2, cmd_ready, a, b);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) $display("FAIL rsp_latency got rsp_valid=%b required 1", rsp_valid);
    else passes++;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({state, cmd_ready, rsp_valid, rsp_err, op_count} !== {3'd0, 1'b0, 1'b0, 1'b0, 8'd0})
      $display("FAIL reset_ctrl got state=%0d ready=%b valid=%b err=%b count=%0d required 0 0 0 0 0",
               state, cmd_ready, rsp_valid, rsp_err, op_count);
    else passes++;
    checks++;
    if (alu_in_sel !== 3'b001 || alu_out_sel !== 7'b0)
      $display("FAIL reset_sel got in_sel=%b out_sel=%b required 001 0000000", alu_in_sel, alu_out_sel);
    else passes++;
    checks++;
    if (rsp_data !== 8'h00 || alu_num1 !== 8'h00 || alu_num2 !== 8'h00)
      $display("FAIL reset_data got rsp=%h num1=%h num2=%h required 00 00 00", rsp_data, alu_num1, alu_num2);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [2:0] is; logic [6:0] os; int c;
    en = 1'b1;
    send_cmd(3'd4, 1'b0, 8'h05, 8'h03, 1'b0, is, os, c);
    checks++;
    if (is !== 3'b010 || os !== 7'b0010000)
      $display("FAIL add_sel got in_sel=%b out_sel=%b required 010 0010000", is, os);
    else passes++;
    checks++;
    if (state !== 3'd1 || op_count !== 8'd1)
      $display("FAIL add_after got state=%0d count=%0d required 1 1", state, op_count);
    else passes++;
  endtask

  task automatic test_mult_err();
    logic [2:0] is; logic [6:0] os; int c;
    send_cmd(3'd6, 1'b0, 8'h20, 8'h10, 1'b1, is, os, c);
    alu_ovf = 1'b0;
    checks++;
    if (state !== 3'd4 || cmd_ready !== 1'b0)
      $display("FAIL mult_error_enter got state=%0d ready=%b required 4 0", state, cmd_ready);
    else passes++;
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd4 || cmd_ready !== 1'b0)
      $display("FAIL error_hold got state=%0d ready=%b required 4 0", state, cmd_ready);
    else passes++;
    en = 1'b1;
    err_ack = 1'b1;
    @(negedge clk);
    err_ack = 1'b0;
    checks++;
    if (state !== 3'd1 || cmd_ready !== 1'b1)
      $display("FAIL err_ack got state=%0d ready=%b required 1 1", state, cmd_ready);
    else passes++;
  endtask

  task automatic test_add_ovf();
    logic [2:0] is; logic [6:0] os; int c;
    send_cmd(3'd4, 1'b0, 8'hF0, 8'h20, 1'b1, is, os, c);
    alu_ovf = 1'b0;
    checks++;
    if (state !== 3'd1) $display("FAIL add_ovf_state got state=%0d required 1", state);
    else passes++;
  endtask

  task automatic test_clr_not();
    logic [2:0] is; logic [6:0] os; int c;
    send_cmd(3'd7, 1'b0, 8'hAA, 8'h55, 1'b0, is, os, c);
    checks++;
    if (is !== 3'b001 || os !== 7'b0)
      $display("FAIL clr_sel got in_sel=%b out_sel=%b required 001 0000000", is, os);
    else passes++;
    send_cmd(3'd3, 1'b1, 8'h12, 8'h00, 1'b0, is, os, c);
    checks++;
    if (is !== 3'b100 || os !== 7'b0001000)
      $display("FAIL not_acc_sel got in_sel=%b out_sel=%b required 100 0001000", is, os);
    else passes++;
    checks++;
    if (alu_in_sel !== 3'b100) $display("FAIL idle_persist got in_sel=%b required 100", alu_in_sel);
    else passes++;
  endtask

  task automatic test_err_ack_ignored();
    err_ack = 1'b1;
    @(negedge clk);
    err_ack = 1'b0;
    checks++;
    if (state !== 3'd1 || cmd_ready !== 1'b1)
      $display("FAIL err_ack_ignored got state=%0d ready=%b required 1 1", state, cmd_ready);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] is; logic [6:0] os; int c, prev;
    for (int i = 0; i < 8; i++) begin
      send_cmd(3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               1'b0, is, os, c);
      if (i > 0) begin
        checks++;
        if (c - prev !== 3) $display("FAIL b2b_spacing got %0d cycles required 3", c - prev);
        else passes++;
      end
      prev = c;
    end
  endtask

  task automatic test_wrap_and_abort();
    logic [2:0] is; logic [6:0] os; int c;
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 256; i++)
      send_cmd(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               1'b0, is, os, c);
    checks++;
    if (op_count !== 8'd0) $display("FAIL count_wrap got %0d required 0", op_count);
    else passes++;
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_src = 1'b0; cmd_a = 8'h01; cmd_b = 8'h01;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || op_count !== 8'd1)
      $display("FAIL abort_setup got state=%0d count=%0d required 3 1", state, op_count);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_acc = 8'h00;
    checks++;
    if (state !== 3'd0 || rsp_valid !== 1'b0 || op_count !== 8'd0)
      $display("FAIL abort got state=%0d valid=%b count=%0d required 0 0 0", state, rsp_valid, op_count);
    else passes++;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL abort_no_rsp got rsp_valid=%b required 0", rsp_valid);
    else passes++;
  endtask

  task automatic test_en_drop();
    logic [2:0] is; logic [6:0] os; int c, n;
    en = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    en = 1'b0;
    send_cmd(3'd1, 1'b0, 8'h0F, 8'hF0, 1'b0, is, os, c);
    checks++;
    if (state !== 3'd1 || op_count !== 8'd1)
      $display("FAIL en_drop_ready got state=%0d count=%0d required 1 1", state, op_count);
    else passes++;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || cmd_ready !== 1'b0)
      $display("FAIL en_drop_off got state=%0d ready=%b required 0 0", state, cmd_ready);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult_err();
    test_add_ovf();
    test_clr_not();
    test_err_ack_ignored();
    test_back_to_back();
    test_wrap_and_abort();
    test_en_drop();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; 8 is the only supported value.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  power-on request; OFF to READY when high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-007 cmd_op  input  3  0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 MULT, 7 CLR.
REQ-008 cmd_src  input  1  0: operand A = cmd_a; 1: operand A = ALU accumulator (previous result).
REQ-009 cmd_a, cmd_b  input  DATA_W each  operands A and B.
REQ-010 alu_in_sel  output  3  one-hot ALU input-mux select: bit2 persist, bit1 load, bit0 reset.
REQ-011 alu_num1, alu_num2  output  DATA_W each  operands driven to ALU.
REQ-012 alu_out_sel  output  7  one-hot ALU output select, bit index = cmd_op (0..6).
REQ-013 alu_result  input  DATA_W  ALU combinational result.
REQ-014 alu_ovf  input  1  ALU multiply overflow flag.
REQ-015 rsp_valid  output  1  one-cycle result strobe; no backpressure.
REQ-016 rsp_data  output  DATA_W  captured result.
REQ-017 rsp_err  output  1  captured overflow error, qualified by rsp_valid.
REQ-018 err_ack  input  1  clears ERROR state.
REQ-019 state  output  3  current FSM state encoding.
REQ-020 op_count  output  8  accepted-command counter.

Function
REQ-021 States: OFF=0, READY=1, ISSUE=2, CAPTURE=3, ERROR=4; codes 5-7 SHALL transition to OFF next cycle.
REQ-022 OFF: cmd_ready=0; en=1 -> READY, else stay.
REQ-023 READY: cmd_ready=1; cmd_valid=1 -> latch op/src/a/b, increment op_count, go ISSUE; en=0 with no valid command -> OFF; cmd_valid takes priority over en=0.
REQ-024 ISSUE (1 cycle): cmd_ready=0; alu_in_sel=reset if op=CLR, persist if src=1, else load; alu_num1=latched A, alu_num2=latched B; alu_out_sel=one-hot(op), all-zero for CLR; next CAPTURE.
REQ-025 CAPTURE (1 cycle): alu_in_sel=persist; sample alu_result into rsp_data (forced 0 for CLR) and rsp_err = alu_ovf AND op=MULT; next ERROR if rsp_err else READY.
REQ-026 rsp_valid SHALL be high exactly the one cycle after CAPTURE; issue-to-response latency = 2 cycles after acceptance; rsp_data/rsp_err hold until next capture.
REQ-027 ERROR: cmd_ready=0; stay until err_ack=1 -> READY; en=0 does not leave ERROR.
REQ-028 err_ack outside ERROR SHALL be ignored.
REQ-029 en deasserted during ISSUE/CAPTURE: operation completes and responds; OFF reached from READY afterwards.
REQ-030 Outside ISSUE, alu_in_sel=persist and alu_out_sel/alu_num1/alu_num2 hold last driven values (accumulator preserved).
REQ-031 op_count wraps 255 -> 0; not affected by CLR or ERROR.
REQ-032 Back-to-back commands: maximum throughput one command per 3 cycles (READY, ISSUE, CAPTURE).

Reset
REQ-033 rst=1 SHALL, on the next edge: state=OFF, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, op_count=0, alu_in_sel=3'b001 (reset), alu_out_sel=0, alu_num1=alu_num2=0.
REQ-034 rst during ISSUE or CAPTURE SHALL abandon the operation with no rsp_valid.
REQ-035 rst has priority over every other input.

Verification
REQ-036 Reset, en=1, cmd ADD src=0 a=8'h05 b=8'h03, ALU model returns 8'h08 -> ISSUE alu_in_sel=3'b010, alu_out_sel=7'b0010000; rsp_valid 2 cycles after acceptance, rsp_data=8'h08, rsp_err=0.
REQ-037 MULT a=8'h20 b=8'h10 with alu_ovf=1 -> rsp_err=1, state=ERROR, cmd_ready=0 until err_ack; err_ack -> READY next cycle.
REQ-038 ADD with alu_ovf=1 forced -> rsp_err=0, returns to READY.
REQ-039 CLR then NOT src=1 -> ISSUE alu_in_sel=3'b001 then 3'b100; CLR rsp_data=0.
REQ-040 256 accepted commands -> op_count=0; rst asserted in CAPTURE -> no rsp_valid, state=OFF, op_count=0.
REQ-041 en=0 and cmd_valid=1 same cycle in READY -> command accepted; en=0 held -> OFF one cycle after response returns to READY.
